// File: rtl/alu_pkg.sv
// alu_pkg: opcode/funct encodings, flag bit positions, issue FSM states and
// the instruction decode helper shared by the ALU issue controller files.
package alu_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Bit positions inside alu_flags
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPERAND = 2'd1,
    ST_EXEC    = 2'd2,
    ST_WB      = 2'd3
  } state_e;

  typedef struct packed {
    logic       wr_en;    // result goes to the register file
    logic [4:0] dest;     // destination register
    logic       ovf_chk;  // add/sub/addi: overflow cancels the write
    logic       is_beq;
    logic       is_bne;
    logic       is_mem;   // lw/sw: result is an effective address
  } dec_t;

  // Classify an instruction; unsupported encodings decode to an all-zero NOP.
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        d.dest = instr[15:11];
        case (instr[5:0])
          FN_ADD, FN_SUB: begin
            d.wr_en   = 1'b1;
            d.ovf_chk = 1'b1;
          end
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU:
            d.wr_en = 1'b1;
          default: d.wr_en = 1'b0;
        endcase
      end
      OP_ADDI: begin
        d.dest    = instr[20:16];
        d.wr_en   = 1'b1;
        d.ovf_chk = 1'b1;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        d.dest  = instr[20:16];
        d.wr_en = 1'b1;
      end
      OP_BEQ:       d.is_beq = 1'b1;
      OP_BNE:       d.is_bne = 1'b1;
      OP_LW, OP_SW: d.is_mem = 1'b1;
      default:      d = '0;
    endcase
    // r0 is hardwired to zero, so a write to it is simply dropped
    if (d.dest == 5'd0) begin
      d.wr_en = 1'b0;
    end else begin
      d.wr_en = d.wr_en;
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction handshake, ALU drive/capture, completion
// report and register-file debug port of the ALU issue controller.
// master = the controller, slave = instruction source / alu / observer.
interface alu_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] alu_instruction;
  logic [31:0] alu_regA;
  logic [31:0] alu_regB;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic        done_valid;
  logic        done_branch_taken;
  logic        done_overflow;
  logic [31:0] done_mem_addr;
  logic [4:0]  dbg_rd_addr;
  logic [31:0] dbg_rd_data;

  modport master (
    input  in_valid, in_instr, alu_result, alu_flags, dbg_rd_addr,
    output in_ready, alu_instruction, alu_regA, alu_regB,
           done_valid, done_branch_taken, done_overflow, done_mem_addr,
           dbg_rd_data
  );

  modport slave (
    output in_valid, in_instr, alu_result, alu_flags, dbg_rd_addr,
    input  in_ready, alu_instruction, alu_regA, alu_regB,
           done_valid, done_branch_taken, done_overflow, done_mem_addr,
           dbg_rd_data
  );
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: 32x32 register file, two operand read ports, one debug read
// port and one write port. r0 always reads as zero and ignores writes.
module alu_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra_addr,
  input  logic [4:0]  rb_addr,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] ra_data,
  output logic [31:0] rb_data,
  output logic [31:0] dbg_data,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] mem_r [0:31];

  // Storage: cleared on reset, single write per cycle, r0 never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem_r[i] <= 32'h0;
      end
    end else if (we && (wa != 5'd0)) begin
      mem_r[wa] <= wd;
    end
  end

  // Combinational reads with r0 forced to zero
  always_comb begin
    ra_data  = (ra_addr  == 5'd0) ? 32'h0 : mem_r[ra_addr];
    rb_data  = (rb_addr  == 5'd0) ? 32'h0 : mem_r[rb_addr];
    dbg_data = (dbg_addr == 5'd0) ? 32'h0 : mem_r[dbg_addr];
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one MIPS instruction at a time, fetches rs/rt from
// the local register file, presents them to the external combinational alu,
// samples result/flags after ALU_WAIT_CYCLES, writes back and reports a
// one-cycle completion (branch outcome, overflow, lw/sw address).
// Build macro ALU_TRAP_EN: an overflowing add/sub/addi latches a sticky trap
// that holds in_ready low until the next reset.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int ALU_WAIT_CYCLES = 1
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_ctrl_if.master bus
);
  state_e      state_r, state_s;
  logic [2:0]  wait_cnt_r;
  logic [31:0] instr_r;
  logic [31:0] alu_instr_r, alu_rega_r, alu_regb_r;
  logic [31:0] result_r;
  logic        zero_r, ovf_r;
  logic        in_ready_r;
  logic        done_valid_r, done_branch_r, done_ovf_r;
  logic [31:0] done_mem_addr_r;
  logic [31:0] rf_ra_s, rf_rb_s, rf_dbg_s;
  dec_t        dec_s;
  logic        accept_s, exec_last_s, wb_s, wb_ovf_s, wb_we_s, branch_s, trap_s;
  logic [31:0] mem_addr_s;
  logic        unused_neg_s;

  // The negative flag does not influence any outcome of this block
  assign unused_neg_s = bus.alu_flags[FLAG_NEG];

  alu_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (instr_r[25:21]),
    .rb_addr  (instr_r[20:16]),
    .dbg_addr (bus.dbg_rd_addr),
    .ra_data  (rf_ra_s),
    .rb_data  (rf_rb_s),
    .dbg_data (rf_dbg_s),
    .we       (wb_we_s),
    .wa       (dec_s.dest),
    .wd       (result_r)
  );

  // Decode the in-flight instruction and form writeback/completion values
  always_comb begin
    dec_s       = decode(alu_instr_r);
    accept_s    = bus.in_valid && in_ready_r;
    exec_last_s = (wait_cnt_r == 3'(ALU_WAIT_CYCLES - 1));
    wb_s        = (state_r == ST_WB);
    wb_ovf_s    = dec_s.ovf_chk && ovf_r;
    wb_we_s     = wb_s && dec_s.wr_en && !wb_ovf_s;
    branch_s    = (dec_s.is_beq && zero_r) || (dec_s.is_bne && !zero_r);
    if (dec_s.is_mem) begin
      mem_addr_s = result_r;
    end else begin
      mem_addr_s = 32'h0;
    end
  end

  // Next-state logic of the serial issue FSM
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_OPERAND;
        else          state_s = ST_IDLE;
      end
      ST_OPERAND: state_s = ST_EXEC;
      ST_EXEC: begin
        if (exec_last_s) state_s = ST_WB;
        else             state_s = ST_EXEC;
      end
      ST_WB:   state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register and EXEC wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 3'd0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_OPERAND) wait_cnt_r <= 3'd0;
      else if (state_r == ST_EXEC) wait_cnt_r <= wait_cnt_r + 3'd1;
      else wait_cnt_r <= wait_cnt_r;
    end
  end

  // Capture the instruction, then drive alu inputs; they hold until next OPERAND
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r     <= 32'h0;
      alu_instr_r <= 32'h0;
      alu_rega_r  <= 32'h0;
      alu_regb_r  <= 32'h0;
    end else begin
      if (accept_s) instr_r <= bus.in_instr;
      if (state_r == ST_OPERAND) begin
        alu_instr_r <= instr_r;
        alu_rega_r  <= rf_ra_s;
        alu_regb_r  <= rf_rb_s;
      end
    end
  end

  // Sample alu result and the flags that matter on the last EXEC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= 32'h0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else if ((state_r == ST_EXEC) && exec_last_s) begin
      result_r <= bus.alu_result;
      zero_r   <= bus.alu_flags[FLAG_ZERO];
      ovf_r    <= bus.alu_flags[FLAG_OVF];
    end
  end

`ifdef ALU_TRAP_EN
  logic trap_r;

  // Sticky trap on a signed-overflow instruction, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_r <= 1'b0;
    else if (wb_s && wb_ovf_s) trap_r <= 1'b1;
  end
  assign trap_s = trap_r || (wb_s && wb_ovf_s);
`else
  assign trap_s = 1'b0;
`endif

  // Registered completion report and ready, which is high only in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r      <= 1'b1;
      done_valid_r    <= 1'b0;
      done_branch_r   <= 1'b0;
      done_ovf_r      <= 1'b0;
      done_mem_addr_r <= 32'h0;
    end else begin
      in_ready_r   <= (state_s == ST_IDLE) && !trap_s;
      done_valid_r <= wb_s;
      if (wb_s) begin
        done_branch_r   <= branch_s;
        done_ovf_r      <= wb_ovf_s;
        done_mem_addr_r <= mem_addr_s;
      end else begin
        done_branch_r   <= 1'b0;
        done_ovf_r      <= 1'b0;
        done_mem_addr_r <= 32'h0;
      end
    end
  end

  assign bus.in_ready          = in_ready_r;
  assign bus.alu_instruction   = alu_instr_r;
  assign bus.alu_regA          = alu_rega_r;
  assign bus.alu_regB          = alu_regb_r;
  assign bus.done_valid        = done_valid_r;
  assign bus.done_branch_taken = done_branch_r;
  assign bus.done_overflow     = done_ovf_r;
  assign bus.done_mem_addr     = done_mem_addr_r;
  assign bus.dbg_rd_data       = rf_dbg_s;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: drives alu_issue_ctrl with directed and random MIPS
// instructions, supplies a behavioural combinational alu and compares every
// completion and the whole register file against an architectural model.
module tb_alu_issue_ctrl;
  localparam int WAIT = 1;

  logic        clk;
  logic        rst_n;
  int          checks;
  int          errors;
  bit          trapped;
  logic [31:0] model_rf [32];
  logic [32:0] env_out;
  bit          d_br, d_ovf;
  logic [31:0] d_mem;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.ALU_WAIT_CYCLES(WAIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural alu: {overflow, result} from instruction and operands
  function automatic logic [32:0] env_alu(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] se, ze, r;
    logic v;
    se = {{16{i[15]}}, i[15:0]};
    ze = {16'h0, i[15:0]};
    r  = 32'h0;
    v  = 1'b0;
    case (i[31:26])
      6'h00: case (i[5:0])
        6'h20: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
        6'h21: r = a + b;
        6'h22: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
        6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2A: r = {31'h0, $signed(a) < $signed(b)};
        6'h2B: r = {31'h0, a < b};
        default: r = 32'h0;
      endcase
      6'h04, 6'h05: r = a - b;
      6'h08: begin r = a + se; v = (a[31] == se[31]) && (r[31] != a[31]); end
      6'h09: r = a + se;
      6'h0A: r = {31'h0, $signed(a) < $signed(se)};
      6'h0B: r = {31'h0, a < se};
      6'h0C: r = a & ze;
      6'h0D: r = a | ze;
      6'h0E: r = a ^ ze;
      6'h23, 6'h2B: r = a + se;
      default: r = 32'h0;
    endcase
    return {v, r};
  endfunction

  always_comb begin
    env_out        = env_alu(bus.alu_instruction, bus.alu_regA, bus.alu_regB);
    bus.alu_result = env_out[31:0];
    bus.alu_flags  = {(env_out[31:0] == 32'h0), env_out[31], env_out[32]};
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Architectural reference: MIPS semantics evaluated with wide integers
  task automatic model_predict(input logic [31:0] instr, output bit we, output logic [4:0] dest,
                               output logic [31:0] val, output bit br, output bit ovf, output logic [31:0] mem);
    logic [31:0] a, b;
    longint sa, sb, simm, wide;
    bit chk;
    a = model_rf[instr[25:21]];
    b = model_rf[instr[20:16]];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    simm = longint'($signed(instr[15:0]));
    we = 0; dest = 5'd0; val = 32'h0; br = 0; ovf = 0; mem = 32'h0; chk = 0; wide = 0;
    if (instr[31:26] == 6'h00) begin
      dest = instr[15:11];
      we = 1;
      case (instr[5:0])
        6'h20: begin wide = sa + sb; chk = 1; end
        6'h21: val = a + b;
        6'h22: begin wide = sa - sb; chk = 1; end
        6'h23: val = a - b;
        6'h24: val = a & b;
        6'h25: val = a | b;
        6'h26: val = a ^ b;
        6'h27: val = ~(a | b);
        6'h2A: val = (sa < sb) ? 32'd1 : 32'd0;
        6'h2B: val = (a < b) ? 32'd1 : 32'd0;
        default: we = 0;
      endcase
    end else begin
      dest = instr[20:16];
      case (instr[31:26])
        6'h08: begin wide = sa + simm; chk = 1; we = 1; end
        6'h09: begin val = a + 32'(simm); we = 1; end
        6'h0A: begin val = (sa < simm) ? 32'd1 : 32'd0; we = 1; end
        6'h0B: begin val = (a < 32'(simm)) ? 32'd1 : 32'd0; we = 1; end
        6'h0C: begin val = a & {16'h0, instr[15:0]}; we = 1; end
        6'h0D: begin val = a | {16'h0, instr[15:0]}; we = 1; end
        6'h0E: begin val = a ^ {16'h0, instr[15:0]}; we = 1; end
        6'h04: br = (a == b);
        6'h05: br = (a != b);
        6'h23, 6'h2B: mem = a + 32'(simm);
        default: we = 0;
      endcase
    end
    if (chk) begin
      val = 32'(wide);
      ovf = (wide != longint'($signed(val)));
      if (ovf) we = 0;
    end
    if (dest == 5'd0) we = 0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus.dbg_rd_addr = 5'(i);
      #1;
      checks++;
      if (bus.dbg_rd_data !== model_rf[i]) begin
        errors++;
        $display("FAIL %s r%0d: dbg_rd_data=%h required %h", tag, i, bus.dbg_rd_data, model_rf[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic dbg_read(input logic [4:0] addr, output logic [31:0] data);
    bus.dbg_rd_addr = addr;
    #1;
    data = bus.dbg_rd_data;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    trapped = 0;
  endtask

  // Issue one instruction, check handshake, latency, completion and registers
  task automatic run_instr(input logic [31:0] instr, input bit hold,
                           output bit obs_br, output bit obs_ovf, output logic [31:0] obs_mem);
    bit e_we, e_br, e_ovf;
    logic [4:0] e_dest;
    logic [31:0] e_val, e_mem;
    int lat, waited;
    model_predict(instr, e_we, e_dest, e_val, e_br, e_ovf, e_mem);
    obs_br = 0; obs_ovf = 0; obs_mem = 32'h0;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 16) begin
      @(posedge clk); #1; waited++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait instr=%h: in_ready=%b required 1", instr, bus.in_ready);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    @(posedge clk); #1;
    if (!hold) bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready instr=%h: in_ready=%b required 0", instr, bus.in_ready);
    end
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus.done_valid === 1'b1) begin lat = c; break; end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (lat != 2 + WAIT) begin
      errors++;
      $display("FAIL latency instr=%h: cycles=%0d required %0d", instr, lat, 2 + WAIT);
    end
    if (lat == 0) return;
    obs_br = bus.done_branch_taken;
    obs_ovf = bus.done_overflow;
    obs_mem = bus.done_mem_addr;
    checks++;
    if ({bus.done_branch_taken, bus.done_overflow} !== {e_br, e_ovf}) begin
      errors++;
      $display("FAIL done_flags instr=%h: branch/ovf=%b%b required %b%b", instr,
               bus.done_branch_taken, bus.done_overflow, e_br, e_ovf);
    end
    checks++;
    if (bus.done_mem_addr !== e_mem) begin
      errors++;
      $display("FAIL done_mem_addr instr=%h: got %h required %h", instr, bus.done_mem_addr, e_mem);
    end
    if (e_we) model_rf[e_dest] = e_val;
`ifdef ALU_TRAP_EN
    if (e_ovf) trapped = 1;
`endif
    @(posedge clk); #1;
    checks++;
    if (bus.done_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse instr=%h: done_valid=%b required 0", instr, bus.done_valid);
    end
    checks++;
    if (bus.alu_instruction !== instr) begin
      errors++;
      $display("FAIL alu_hold: alu_instruction=%h required %h", bus.alu_instruction, instr);
    end
    checks++;
    if (bus.in_ready !== (trapped ? 1'b0 : 1'b1)) begin
      errors++;
      $display("FAIL ready_after instr=%h: in_ready=%b required %b", instr, bus.in_ready, !trapped);
    end
    check_regs("regfile");
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.in_ready, bus.done_valid, bus.done_branch_taken, bus.done_overflow} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/done/br/ovf=%b%b%b%b required 1000", bus.in_ready,
               bus.done_valid, bus.done_branch_taken, bus.done_overflow);
    end
    checks++;
    if ({bus.alu_instruction, bus.alu_regA, bus.alu_regB, bus.done_mem_addr} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: instr=%h a=%h b=%h mem=%h required 0", bus.alu_instruction,
               bus.alu_regA, bus.alu_regB, bus.done_mem_addr);
    end
    check_regs("reset_regs");
  endtask

  task automatic test_basic();
    logic [31:0] v;
    run_instr(32'h24010005, 0, d_br, d_ovf, d_mem);
    run_instr(32'h00211821, 0, d_br, d_ovf, d_mem);
    dbg_read(5'd3, v);
    checks++;
    if (v !== 32'h0000000A) begin
      errors++;
      $display("FAIL basic_r3: got %h required 0000000a", v);
    end
  endtask

  task automatic test_branches();
    bit br;
    run_instr(enc_i(6'h04, 5'd1, 5'd1, 16'h0010), 0, br, d_ovf, d_mem);
    checks++;
    if (br !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b required 1", br); end
    run_instr(enc_i(6'h05, 5'd1, 5'd1, 16'h0010), 0, br, d_ovf, d_mem);
    checks++;
    if (br !== 1'b0) begin errors++; $display("FAIL bne_taken: got %b required 0", br); end
    run_instr(enc_i(6'h05, 5'd1, 5'd3, 16'h0020), 0, br, d_ovf, d_mem);
    checks++;
    if (br !== 1'b1) begin errors++; $display("FAIL bne_diff: got %b required 1", br); end
  endtask

  task automatic test_mem_r0();
    logic [31:0] mem, v;
    run_instr(enc_i(6'h09, 5'd0, 5'd1, 16'h0100), 0, d_br, d_ovf, d_mem);
    run_instr(enc_i(6'h23, 5'd1, 5'd2, 16'h700F), 0, d_br, d_ovf, mem);
    checks++;
    if (mem !== 32'h0000710F) begin errors++; $display("FAIL lw_addr: got %h required 0000710f", mem); end
    dbg_read(5'd2, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL lw_nowb: r2=%h required 0", v); end
    run_instr(enc_i(6'h2B, 5'd1, 5'd4, 16'hFFF0), 0, d_br, d_ovf, mem);
    checks++;
    if (mem !== 32'h000000F0) begin errors++; $display("FAIL sw_addr: got %h required 000000f0", mem); end
    run_instr(enc_i(6'h09, 5'd0, 5'd0, 16'h0007), 0, d_br, d_ovf, d_mem);
    dbg_read(5'd0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL r0_write: r0=%h required 0", v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    run_instr(enc_i(6'h09, 5'd0, 5'd6, 16'h0010), 0, d_br, d_ovf, d_mem);
    run_instr(enc_i(6'h09, 5'd6, 5'd6, 16'h0001), 1, d_br, d_ovf, d_mem);
    dbg_read(5'd6, v);
    checks++;
    if (v !== 32'h00000011) begin errors++; $display("FAIL held_valid_once: r6=%h required 00000011", v); end
    run_instr(enc_r(5'd6, 5'd6, 5'd7, 6'h21), 0, d_br, d_ovf, d_mem);
    run_instr(enc_r(5'd7, 5'd6, 5'd8, 6'h23), 0, d_br, d_ovf, d_mem);
    run_instr(32'hFC000000, 0, d_br, d_ovf, d_mem);
  endtask

  task automatic test_random();
    logic [5:0] fns [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                             6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h3F};
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] instr;
    for (int n = 0; n < 40; n++) begin
      if (trapped) apply_reset();
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      case ($urandom_range(0, 9))
        0, 1: instr = enc_i(6'h09, rs, rt, imm);
        2, 3: instr = enc_r(rs, rt, rd, fns[$urandom_range(0, 11)]);
        4: instr = enc_i(6'h0C + 6'($urandom_range(0, 2)), rs, rt, imm);
        5: instr = enc_i(6'h08, rs, rt, imm);
        6: instr = enc_i(6'h04 + 6'($urandom_range(0, 1)), rs, rt, imm);
        7: instr = enc_i(($urandom_range(0, 1) == 0) ? 6'h23 : 6'h2B, rs, rt, imm);
        8: instr = enc_i(6'h0A + 6'($urandom_range(0, 1)), rs, rt, imm);
        default: instr = enc_i(6'h3F, rs, rt, imm);
      endcase
      run_instr(instr, 0, d_br, d_ovf, d_mem);
    end
  endtask

  task automatic test_overflow();
    bit ovf;
    logic [31:0] v;
    apply_reset();
    run_instr(enc_i(6'h09, 5'd0, 5'd4, 16'h4000), 0, d_br, d_ovf, d_mem);
    for (int k = 0; k < 17; k++) run_instr(enc_r(5'd4, 5'd4, 5'd4, 6'h21), 0, d_br, d_ovf, d_mem);
    run_instr(enc_i(6'h09, 5'd4, 5'd1, 16'hFFFF), 0, d_br, d_ovf, d_mem);
    dbg_read(5'd1, v);
    checks++;
    if (v !== 32'h7FFFFFFF) begin errors++; $display("FAIL ovf_preload: r1=%h required 7fffffff", v); end
    run_instr(enc_i(6'h09, 5'd0, 5'd2, 16'h0055), 0, d_br, d_ovf, d_mem);
    run_instr(enc_r(5'd1, 5'd1, 5'd2, 6'h20), 0, d_br, ovf, d_mem);
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL add_ovf: done_overflow=%b required 1", ovf); end
    dbg_read(5'd2, v);
    checks++;
    if (v !== 32'h00000055) begin errors++; $display("FAIL ovf_nowb: r2=%h required 00000055", v); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
`ifdef ALU_TRAP_EN
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL trap_ready: in_ready=%b required 0", bus.in_ready); end
`else
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready: in_ready=%b required 1", bus.in_ready); end
`endif
  endtask

  task automatic test_reset_mid();
    bit seen;
    apply_reset();
    run_instr(enc_i(6'h09, 5'd0, 5'd1, 16'h0033), 0, d_br, d_ovf, d_mem);
    bus.in_valid = 1'b1;
    bus.in_instr = enc_i(6'h09, 5'd1, 5'd5, 16'h0001);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.done_valid} !== 2'b10) begin
      errors++;
      $display("FAIL mid_reset_async: ready/done=%b%b required 10", bus.in_ready, bus.done_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    trapped = 0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done_valid === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL mid_reset_done: done_valid pulsed, required none"); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: in_ready=%b required 1", bus.in_ready); end
    check_regs("mid_reset_regs");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    trapped = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = 32'h0;
    bus.dbg_rd_addr = 5'd0;
    test_reset();
    test_basic();
    test_branches();
    test_mem_r0();
    test_back_to_back();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
